// File: rtl/io_fila_entrada_saida.sv
// io_fila_entrada_saida
//   Processor I/O unit. Debounces the enter key and queues switch samples
//   in a small FIFO so several values can be keyed ahead of IN. IN stalls
//   while the queue is empty. OUT values are latched as magnitude plus sign
//   for the 7-segment display driver.
// Ports
//   clock, reset            processor clock, synchronous active-high reset
//   enter, entrada          raw key (asynchronous) and raw switches
//   in_req/in_data/in_ack   IN handshake; in_data is the extended FIFO head
//   stall                   IN requested while queue is empty
//   out_req/out_data        OUT request and value
//   segmentos/neg           registered |out value| and its sign
//   nivel, overflow         FIFO occupancy, sticky dropped-press flag
module io_fila_entrada_saida #(
  parameter int DATA_W           = 32,
  parameter int SW_W             = 18,
  parameter int FIFO_DEPTH       = 4,
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int ENTER_ACTIVE_LOW = 1,
  parameter int SIGN_EXT         = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enter,
  input  logic [SW_W-1:0]                 entrada,
  input  logic                            in_req,
  output logic [DATA_W-1:0]               in_data,
  output logic                            in_ack,
  output logic                            stall,
  input  logic                            out_req,
  input  logic [DATA_W-1:0]               out_data,
  output logic [DATA_W-1:0]               segmentos,
  output logic                            neg,
  output logic [$clog2(FIFO_DEPTH):0]     nivel,
  output logic                            overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int NIVEL_W = PTR_W + 1;
  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic IDLE_LEVEL = (ENTER_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {RELEASED, PRESSED} deb_state_t;

  // Synchroniser: reset to the idle pin level so no false edge appears
  logic sync1_reg, sync2_reg;
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_reg <= IDLE_LEVEL;
      sync2_reg <= IDLE_LEVEL;
    end else begin
      sync1_reg <= enter;
      sync2_reg <= sync1_reg;
    end
  end

  logic pressed_level;
  assign pressed_level = sync2_reg ^ IDLE_LEVEL;

  // Debouncer
  deb_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             differ, flip, push_ev;

  assign differ  = pressed_level != (state_reg == PRESSED);
  // The flip edge is also the push edge, so entrada is written on the flip
  assign flip    = differ && (cnt_reg == CNT_LAST);
  assign push_ev = flip && (state_reg == RELEASED);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= RELEASED;
      cnt_reg   <= '0;
    end else if (!differ) begin
      cnt_reg <= '0;
    end else if (flip) begin
      state_reg <= (state_reg == RELEASED) ? PRESSED : RELEASED;
      cnt_reg   <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // FIFO
  logic [SW_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [NIVEL_W-1:0] nivel_reg;
  logic               overflow_reg;
  logic               empty, full, pop, push_ok;

  assign empty   = (nivel_reg == '0);
  assign full    = (nivel_reg == NIVEL_W'(FIFO_DEPTH));
  // Reset gating makes stall drop in the reset cycle itself
  assign pop     = in_req && !empty && !reset;
  // A pop in the same cycle frees the slot a full FIFO needs
  assign push_ok = push_ev && (!full || pop) && !reset;

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_reg] <= entrada;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      nivel_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   nivel_reg <= nivel_reg + NIVEL_W'(1);
        2'b01:   nivel_reg <= nivel_reg - NIVEL_W'(1);
        default: nivel_reg <= nivel_reg;
      endcase
      if (push_ev && full && !pop) overflow_reg <= 1'b1;
    end
  end

  // Head extension to CPU width
  logic [SW_W-1:0]   head;
  logic [DATA_W-1:0] head_ext;
  assign head = mem[rd_ptr_reg];

  generate
    if (SW_W < DATA_W) begin : g_ext
      if (SIGN_EXT != 0) begin : g_sign
        assign head_ext = {{(DATA_W-SW_W){head[SW_W-1]}}, head};
      end else begin : g_zero
        assign head_ext = {{(DATA_W-SW_W){1'b0}}, head};
      end
    end else begin : g_same
      assign head_ext = head;
    end
  endgenerate

  assign in_data  = empty ? '0 : head_ext;
  assign in_ack   = pop;
  assign stall    = in_req && empty && !reset;
  assign nivel    = nivel_reg;
  assign overflow = overflow_reg;

  // OUT path: two's-complement magnitude; the most negative value maps to
  // itself, which reads correctly as an unsigned magnitude
  logic [DATA_W-1:0] seg_reg;
  logic              neg_reg;
  logic [DATA_W-1:0] magnitude;
  assign magnitude = out_data[DATA_W-1] ? (~out_data + DATA_W'(1)) : out_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      seg_reg <= '0;
      neg_reg <= 1'b0;
    end else if (out_req) begin
      seg_reg <= magnitude;
      neg_reg <= out_data[DATA_W-1];
    end
  end

  assign segmentos = seg_reg;
  assign neg       = neg_reg;

endmodule

// File: tb/tb_io_fila_entrada_saida.sv
module tb_io_fila_entrada_saida;

  logic        clock = 1'b0;
  logic        reset, enter, in_req, out_req;
  logic [17:0] entrada;
  logic [31:0] out_data;
  logic [31:0] in_data, segmentos, in_data_z, segmentos_z;
  logic        in_ack, stall, neg, overflow, in_ack_z, stall_z, neg_z, overflow_z;
  logic [2:0]  nivel, nivel_z;

  int checks = 0;
  int errors = 0;
  logic [17:0] sb[$];
  logic        exp_ovf;

  always #5 clock = ~clock;

  io_fila_entrada_saida dut (
    .clock(clock), .reset(reset), .enter(enter), .entrada(entrada),
    .in_req(in_req), .in_data(in_data), .in_ack(in_ack), .stall(stall),
    .out_req(out_req), .out_data(out_data), .segmentos(segmentos),
    .neg(neg), .nivel(nivel), .overflow(overflow));

  io_fila_entrada_saida #(.SIGN_EXT(0)) dut_z (
    .clock(clock), .reset(reset), .enter(enter), .entrada(entrada),
    .in_req(in_req), .in_data(in_data_z), .in_ack(in_ack_z), .stall(stall_z),
    .out_req(out_req), .out_data(out_data), .segmentos(segmentos_z),
    .neg(neg_z), .nivel(nivel_z), .overflow(overflow_z));

  function automatic logic [31:0] sx(input logic [17:0] v);
    return {{14{v[17]}}, v};
  endfunction

  function automatic logic [31:0] zx(input logic [17:0] v);
    return {14'b0, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Press held long enough to be accepted; model mirrors FIFO capacity
  task automatic press(input logic [17:0] v);
    entrada = v;
    enter = 1'b0;
    cycles(6);
    enter = 1'b1;
    cycles(8);
    if (sb.size() < 4) sb.push_back(v);
    else exp_ovf = 1'b1;
  endtask

  task automatic do_in(input string tag);
    logic [17:0] e;
    in_req = 1'b1;
    #1;
    chk({tag, "_ack"}, in_ack, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, in_data, sx(e));
      chk({tag, "_data_z"}, in_data_z, zx(e));
    end
    @(negedge clock);
    in_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
  endtask

  initial begin
    int lat;
    reset = 1'b1; enter = 1'b1; in_req = 1'b0; out_req = 1'b0;
    entrada = '0; out_data = '0; exp_ovf = 1'b0;
    cycles(3);
    reset = 1'b0;
    #1;
    chk("rst_nivel", nivel, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_seg", segmentos, 0);
    chk("rst_neg", neg, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ack", in_ack, 0);
    chk("rst_data", in_data, 0);

    // Too-short press: 3 cycles against a 4-cycle debounce
    entrada = 18'h1;
    enter = 1'b0;
    cycles(3);
    enter = 1'b1;
    cycles(8);
    chk("short_nivel", nivel, 0);

    // Extension, both variants
    press(18'h3FFFF);
    chk("ext_nivel", nivel, 32'(sb.size()));
    do_in("ext");
    chk("ext_nivel_after", nivel, 0);

    // Stall until the cycle after the push
    in_req = 1'b1;
    #1;
    chk("stall_idle", stall, 1);
    entrada = 18'd5;
    enter = 1'b0;
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clock);
      if (in_ack) break;
      chk("stall_wait", stall, 1);
    end
    chk("ack_latency", lat, 6);
    chk("stall_data", in_data, 32'd5);
    @(negedge clock);
    chk("stall_again", stall, 1);
    chk("stall_again_ack", in_ack, 0);
    in_req = 1'b0;
    enter = 1'b1;
    cycles(8);

    // Overfill: 5 presses into 4 entries
    for (int v = 1; v <= 5; v++) press(18'(v));
    chk("full_nivel", nivel, 4);
    chk("full_ovf", overflow, 32'(exp_ovf));
    for (int k = 0; k < 4; k++) begin
      do_in("drain");
      chk("drain_nivel", nivel, 32'(sb.size()));
    end
    chk("drain_ovf_sticky", overflow, 1);

    // Full with simultaneous push and pop
    do_reset();
    for (int v = 1; v <= 4; v++) press(18'(v));
    chk("fp_nivel_pre", nivel, 4);
    entrada = 18'd5;
    enter = 1'b0;
    cycles(5);
    in_req = 1'b1;
    #1;
    chk("fp_ack", in_ack, 1);
    chk("fp_pop_data", in_data, sx(sb.pop_front()));
    sb.push_back(18'd5);
    @(negedge clock);
    in_req = 1'b0;
    chk("fp_nivel", nivel, 4);
    chk("fp_head", in_data, sx(sb[0]));
    chk("fp_ovf", overflow, 0);
    enter = 1'b1;
    cycles(8);
    for (int k = 0; k < 4; k++) do_in("fp_drain");
    chk("fp_nivel_end", nivel, 0);

    // Reset mid-stall drops stall at once and loses the pending press
    in_req = 1'b1;
    enter = 1'b0;
    cycles(3);
    #1;
    chk("ms_stall", stall, 1);
    reset = 1'b1;
    #1;
    chk("ms_stall_rst", stall, 0);
    @(negedge clock);
    reset = 1'b0;
    enter = 1'b1;
    in_req = 1'b0;
    cycles(8);
    chk("ms_nivel", nivel, 0);

    // OUT path
    out_req = 1'b1; out_data = -32'sd7;
    @(negedge clock);
    out_req = 1'b0;
    chk("out_m7_seg", segmentos, 7);
    chk("out_m7_neg", neg, 1);
    out_data = 32'd3;
    @(negedge clock);
    chk("out_hold_seg", segmentos, 7);
    out_req = 1'b1; out_data = 32'h8000_0000;
    @(negedge clock);
    chk("out_min_seg", segmentos, 32'h8000_0000);
    chk("out_min_neg", neg, 1);
    out_data = 32'd123;
    @(negedge clock);
    out_req = 1'b0;
    chk("out_pos_seg", segmentos, 123);
    chk("out_pos_neg", neg, 0);

    // Reset discards pending FIFO data and clears display
    out_req = 1'b1; out_data = -32'sd9;
    @(negedge clock);
    out_req = 1'b0;
    press(18'h2A);
    chk("pre_rst_nivel", nivel, 1);
    do_reset();
    chk("fin_nivel", nivel, 0);
    chk("fin_data", in_data, 0);
    chk("fin_seg", segmentos, 0);
    chk("fin_neg", neg, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
